cmd_fifo_arbiter: RTL and testbench

- Controller for the 64-bit, 256-deep single-clock command FIFO (scfifo, non-showahead, 1-cycle read latency) that feeds the rasterizer command stream.
- Shares the FIFO write port between two producers: port 0 is the HPS command bridge, port 1 is the frame-control sequencer. Arbitration is round-robin.
- Converts the FIFO's rdreq/q protocol into a full-throughput valid/ready stream for the consumer.
- Sequences a synchronous flush of the FIFO.

---
 rtl/cmd_fifo_arbiter.sv | 148 ++++++++++++++
 tb/tb_cmd_fifo_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_fifo_arbiter.sv
// Command FIFO controller: round-robin write arbiter for two producers, a
// 2-entry skid that turns the non-showahead FIFO read port into a
// full-rate valid/ready stream, and a flush sequencer.
// Ports:
//   clock, reset_n        : clock, async active-low reset
//   in0_*, in1_*          : producer streams (valid/data/ready)
//   out_*                 : consumer stream (valid/data/ready)
//   flush_req, flush_busy : flush pulse in, flush in progress out
//   fifo_*                : scfifo ports (sclr/wrreq/data/full/empty/usedw/rdreq/q)
module cmd_fifo_arbiter #(
  parameter int WIDTH      = 64,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in0_valid,
  input  logic [WIDTH-1:0]      in0_data,
  output logic                  in0_ready,
  input  logic                  in1_valid,
  input  logic [WIDTH-1:0]      in1_data,
  output logic                  in1_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  fifo_sclr,
  output logic                  fifo_wrreq,
  output logic [WIDTH-1:0]      fifo_data,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  input  logic [DEPTH_LOG2-1:0] fifo_usedw,
  output logic                  fifo_rdreq,
  input  logic [WIDTH-1:0]      fifo_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             rr_last;
  logic [1:0]       count;
  logic [WIDTH-1:0] skid0;
  logic [WIDTH-1:0] skid1;
  logic             rd_pending;

  logic             idle;
  logic             can_write;
  logic             grant1;
  logic             pop;
  logic             cap;
  logic [2:0]       occ;

  // usedw is kept on the port for debug taps only
  logic unused_usedw;
  assign unused_usedw = ^fifo_usedw;

  assign idle = (state == IDLE);

  // Gate with reset_n so every handshake output reads 0 while in reset
  assign can_write = reset_n && idle && !fifo_full;

  // Both requesting: grant the port that did not win last time
  assign grant1 = in1_valid && (!in0_valid || !rr_last);

  assign fifo_wrreq = can_write && (in0_valid || in1_valid);
  assign fifo_data  = grant1 ? in1_data : in0_data;
  assign in0_ready  = can_write && in0_valid && !grant1;
  assign in1_ready  = can_write && grant1;

  assign out_valid = (count != 2'd0);
  assign out_data  = skid0;
  assign pop       = out_valid && out_ready;
  assign cap       = rd_pending;

  // Occupancy after this cycle's pop, counting the read in flight
  assign occ = {1'b0, count} + {2'b00, rd_pending} - {2'b00, pop};

  assign fifo_rdreq = reset_n && idle && !fifo_empty && (occ < 3'd2);

  always_comb begin
    state_nxt  = state;
    fifo_sclr  = 1'b0;
    flush_busy = 1'b1;
    unique case (state)
      IDLE: begin
        flush_busy = 1'b0;
        if (flush_req) state_nxt = CLEAR;
      end
      CLEAR: begin
        fifo_sclr = 1'b1;
        state_nxt = DRAIN;
      end
      DRAIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_last    <= 1'b1;
      rd_pending <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_pending <= fifo_rdreq;
      if (fifo_wrreq) rr_last <= grant1;
    end
  end

  // Skid: words are only taken in IDLE, so a read landing in
  // CLEAR or DRAIN is dropped along with the flushed contents.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= 2'd0;
      skid0 <= '0;
      skid1 <= '0;
    end else if (state == CLEAR) begin
      count <= 2'd0;
    end else if (idle) begin
      unique case ({cap, pop})
        2'b10: begin
          if (count == 2'd0) skid0 <= fifo_q;
          else               skid1 <= fifo_q;
          count <= count + 2'd1;
        end
        2'b01: begin
          skid0 <= skid1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            skid0 <= fifo_q;
          end else begin
            skid0 <= skid1;
            skid1 <= fifo_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_fifo_arbiter.sv
// Directed bench for cmd_fifo_arbiter with a behavioural 256x64
// non-showahead scfifo model attached to the fifo_* ports.
module tb_cmd_fifo_arbiter;

  localparam int W = 64;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         in0_valid = 1'b0;
  logic [W-1:0] in0_data = '0;
  logic         in0_ready;
  logic         in1_valid = 1'b0;
  logic [W-1:0] in1_data = '0;
  logic         in1_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 1'b0;
  logic         flush_req = 1'b0;
  logic         flush_busy;
  logic         fifo_sclr;
  logic         fifo_wrreq;
  logic [W-1:0] fifo_data;
  logic         fifo_full;
  logic         fifo_empty;
  logic [7:0]   fifo_usedw;
  logic         fifo_rdreq;
  logic [W-1:0] fifo_q;

  always #5 clock = ~clock;

  cmd_fifo_arbiter #(.WIDTH(W), .DEPTH_LOG2(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in0_valid  (in0_valid),
    .in0_data   (in0_data),
    .in0_ready  (in0_ready),
    .in1_valid  (in1_valid),
    .in1_data   (in1_data),
    .in1_ready  (in1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .fifo_sclr  (fifo_sclr),
    .fifo_wrreq (fifo_wrreq),
    .fifo_data  (fifo_data),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_usedw (fifo_usedw),
    .fifo_rdreq (fifo_rdreq),
    .fifo_q     (fifo_q)
  );

  // scfifo model: not touched by reset_n, cleared only by sclr
  logic [W-1:0] mem [256];
  logic [7:0]   wp = '0;
  logic [7:0]   rp = '0;
  logic [8:0]   cnt = '0;
  logic [W-1:0] q_r = '0;
  int           ovf = 0;

  assign fifo_full  = (cnt == 9'd256);
  assign fifo_empty = (cnt == 9'd0);
  assign fifo_usedw = cnt[7:0];
  assign fifo_q     = q_r;

  always @(posedge clock) begin
    if (fifo_sclr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      logic w, r;
      w = fifo_wrreq && !fifo_full;
      r = fifo_rdreq && !fifo_empty;
      if (fifo_wrreq && fifo_full)  ovf <= ovf + 1;
      if (fifo_rdreq && fifo_empty) ovf <= ovf + 1;
      if (w) begin
        mem[wp] <= fifo_data;
        wp <= wp + 8'd1;
      end
      if (r) begin
        q_r <= mem[rp];
        rp <= rp + 8'd1;
      end
      cnt <= cnt + {8'd0, w} - {8'd0, r};
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  logic [W-1:0] p0q[$];
  logic [W-1:0] p1q[$];
  logic [W-1:0] rxq[$];
  logic         s_r0, s_r1, s_wr, s_rd, s_sclr, s_busy, s_ov, s_empty;
  logic [W-1:0] s_fd;

  // Called on a falling edge; drives, samples 1 time unit later,
  // then advances to the next falling edge.
  task automatic step(input logic ordy, input logic freq);
    in0_valid = (p0q.size() > 0);
    in0_data  = in0_valid ? p0q[0] : '0;
    in1_valid = (p1q.size() > 0);
    in1_data  = in1_valid ? p1q[0] : '0;
    out_ready = ordy;
    flush_req = freq;
    #1;
    s_r0 = in0_ready;
    s_r1 = in1_ready;
    s_wr = fifo_wrreq;
    s_fd = fifo_data;
    s_rd = fifo_rdreq;
    s_sclr = fifo_sclr;
    s_busy = flush_busy;
    s_ov = out_valid;
    s_empty = fifo_empty;
    if (out_valid && out_ready) rxq.push_back(out_data);
    if (in0_ready) void'(p0q.pop_front());
    if (in1_ready) void'(p1q.pop_front());
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    p0q.delete();
    p1q.delete();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic         v0;
    logic         v1;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         e_r0;
    logic         e_r1;
    logic         e_wr;
    logic [W-1:0] e_fd;
  } vec_t;

  vec_t         tbl [10];
  logic [W-1:0] exp_rx [9];

  initial begin
    int errs;
    int fe, fv, nwr;
    int pc[$];
    logic [7:0] rr_seq;
    logic [1:0] maxc;
    logic pat [4];

    tbl[0] = '{1'b1, 1'b1, 64'h10, 64'h20, 1'b1, 1'b0, 1'b1, 64'h10};
    tbl[1] = '{1'b1, 1'b1, 64'h11, 64'h21, 1'b0, 1'b1, 1'b1, 64'h21};
    tbl[2] = '{1'b1, 1'b1, 64'h12, 64'h22, 1'b1, 1'b0, 1'b1, 64'h12};
    tbl[3] = '{1'b0, 1'b1, 64'h13, 64'h23, 1'b0, 1'b1, 1'b1, 64'h23};
    tbl[4] = '{1'b0, 1'b1, 64'h14, 64'h24, 1'b0, 1'b1, 1'b1, 64'h24};
    tbl[5] = '{1'b1, 1'b1, 64'h15, 64'h25, 1'b1, 1'b0, 1'b1, 64'h15};
    tbl[6] = '{1'b1, 1'b0, 64'h16, 64'h26, 1'b1, 1'b0, 1'b1, 64'h16};
    tbl[7] = '{1'b1, 1'b1, 64'h17, 64'h27, 1'b0, 1'b1, 1'b1, 64'h27};
    tbl[8] = '{1'b0, 1'b0, 64'h18, 64'h28, 1'b0, 1'b0, 1'b0, 64'h0};
    tbl[9] = '{1'b1, 1'b1, 64'h19, 64'h29, 1'b1, 1'b0, 1'b1, 64'h19};
    exp_rx = '{64'h10, 64'h21, 64'h12, 64'h23, 64'h24,
               64'h15, 64'h16, 64'h27, 64'h19};

    // Reset: all outputs 0 even with every request input high
    @(negedge clock);
    p0q.push_back(64'hAA);
    p1q.push_back(64'hBB);
    step(1'b1, 1'b1);
    chk("reset_outputs",
        {57'd0, s_sclr, s_wr, s_rd, s_ov, s_busy, s_r0, s_r1}, '0);
    p0q.delete();
    p1q.delete();
    reset_n = 1'b1;

    // Table-driven arbitration vectors
    foreach (tbl[i]) begin
      p0q.delete();
      p1q.delete();
      if (tbl[i].v0) p0q.push_back(tbl[i].d0);
      if (tbl[i].v1) p1q.push_back(tbl[i].d1);
      step(1'b1, 1'b0);
      chk($sformatf("vec%0d_ready_wr", i), {61'd0, s_r0, s_r1, s_wr},
          {61'd0, tbl[i].e_r0, tbl[i].e_r1, tbl[i].e_wr});
      if (tbl[i].e_wr) chk($sformatf("vec%0d_fifo_data", i), s_fd, tbl[i].e_fd);
    end
    p0q.delete();
    p1q.delete();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    chk("vec_rx_count", rxq.size(), 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("vec_rx%0d", i), (i < rxq.size()) ? rxq[i] : '1, exp_rx[i]);

    // A, B, C back-to-back with first-word latency
    rxq.delete();
    p0q = '{64'hA, 64'hB, 64'hC};
    fe = -1; fv = -1; nwr = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0);
      if (s_wr) nwr++;
      if (!s_empty && fe < 0) fe = i;
      if (s_ov && fv < 0) fv = i;
      if (s_ov) pc.push_back(i);
    end
    chk("abc_wrreq_cycles", nwr, 3);
    chk("abc_first_latency", fv - fe, 2);
    chk("abc_rx_count", rxq.size(), 3);
    chk("abc_rx_order", (rxq.size() == 3) ? {rxq[0][3:0], rxq[1][3:0], rxq[2][3:0]} : '0,
        64'hABC);
    chk("abc_consecutive", (pc.size() == 3) ? pc[2] - pc[0] : -1, 2);

    // Round-robin with both producers streaming
    do_reset();
    rxq.delete();
    for (int i = 0; i < 4; i++) begin
      p0q.push_back(64'h10 + i);
      p1q.push_back(64'h20 + i);
    end
    rr_seq = '0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0);
      if (i < 8) rr_seq[7-i] = s_r0;
    end
    chk("rr_in0_ready_seq", rr_seq, 8'b1010_1010);
    chk("rr_rx_count", rxq.size(), 8);
    errs = 0;
    for (int i = 0; i < 8; i++)
      if (i >= rxq.size() ||
          rxq[i] != ((i % 2 == 0) ? 64'h10 + i / 2 : 64'h20 + i / 2)) errs++;
    chk("rr_rx_order_errs", errs, 0);

    // Fill to full with consumer stalled, then drain
    rxq.delete();
    for (int i = 0; i < 258; i++) p1q.push_back(i);
    for (int i = 0; i < 400 && p1q.size() > 0; i++) step(1'b0, 1'b0);
    chk("fill_all_accepted", p1q.size(), 0);
    chk("fill_fifo_full", fifo_full, 1);
    p1q.push_back(64'h999);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      chk($sformatf("full_in1_ready%0d", i), s_r1, 0);
    end
    p1q.delete();
    for (int i = 0; i < 600 && rxq.size() < 258; i++) step(1'b1, 1'b0);
    chk("drain_count", rxq.size(), 258);
    errs = 0;
    for (int i = 0; i < rxq.size(); i++) if (rxq[i] != i) errs++;
    chk("drain_order_errs", errs, 0);
    chk("drain_last", (rxq.size() > 0) ? rxq[rxq.size()-1] : '1, 257);

    // Consumer stalls 1,0,0,1 while streaming
    rxq.delete();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) p0q.push_back(64'h30 + i);
    maxc = '0;
    for (int i = 0; i < 60 && rxq.size() < 8; i++) begin
      step(pat[i % 4], 1'b0);
      if (dut.count > maxc) maxc = dut.count;
    end
    chk("toggle_skid_max_le2", (maxc <= 2'd2), 1);
    chk("toggle_rx_count", rxq.size(), 8);
    errs = 0;
    for (int i = 0; i < rxq.size(); i++) if (rxq[i] != 64'h30 + i) errs++;
    chk("toggle_order_errs", errs, 0);

    // Flush with a read in flight
    rxq.delete();
    for (int i = 0; i < 5; i++) p0q.push_back(64'h40 + i);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("flush_read_in_flight", s_rd, 1);
    fe = 0; fv = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, i == 0);
      if (s_sclr) fe++;
      if (s_busy) fv++;
    end
    chk("flush_sclr_cycles", fe, 1);
    chk("flush_busy_cycles", fv, 2);
    chk("flush_out_valid", s_ov, 0);
    chk("flush_fifo_empty", cnt, 0);
    rxq.delete();
    p0q.push_back(64'h55);
    for (int i = 0; i < 10 && rxq.size() == 0; i++) step(1'b1, 1'b0);
    chk("post_flush_count", rxq.size(), 1);
    chk("post_flush_first", (rxq.size() > 0) ? rxq[0] : '1, 64'h55);

    // Async reset mid-stream with a full skid
    for (int i = 0; i < 3; i++) p0q.push_back(64'h60 + i);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    chk("pre_reset_out_valid", s_ov, 1);
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    out_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {57'd0, fifo_sclr, fifo_wrreq, fifo_rdreq, out_valid, flush_busy,
         in0_ready, in1_ready}, '0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    p0q = '{64'h70};
    p1q = '{64'h80};
    step(1'b0, 1'b0);
    chk("post_reset_grant", {62'd0, s_r0, s_r1}, 64'b10);

    chk("fifo_over_underflow", ovf, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
